// File: rtl/wb_interconnect_reg.sv
// Registered 1:N Wishbone classic interconnect: one-cycle registered request stage,
// per-transaction timeout watchdog and abort handling between a master and N slaves.
module wb_interconnect_reg #(
    parameter int N = 2,
    parameter int AW = 32,
    parameter int DW = 32,
    parameter logic [N*2*AW-1:0] ADDR_RANGES = '0,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                m_cyc,
    input  logic                m_stb,
    input  logic                m_we,
    input  logic [AW-1:0]       m_addr,
    input  logic [DW-1:0]       m_wdata,
    input  logic [DW/8-1:0]     m_sel,
    output logic [DW-1:0]       m_rdata,
    output logic                m_ack,
    output logic                m_err,
    output logic [N-1:0]        s_cyc,
    output logic [N-1:0]        s_stb,
    output logic [N-1:0]        s_we,
    output logic [N*AW-1:0]     s_addr,
    output logic [N*DW-1:0]     s_wdata,
    output logic [N*DW/8-1:0]   s_sel,
    input  logic [N*DW-1:0]     s_rdata,
    input  logic [N-1:0]        s_ack,
    input  logic [N-1:0]        s_err
);

    localparam int SW = DW / 8;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int TW_RAW = $clog2(TIMEOUT + 1);
    localparam int TW = (TW_RAW < 8) ? 8 : ((TW_RAW > 32) ? 32 : TW_RAW);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t           state_r;
    state_t           next_state_s;
    logic [IW-1:0]    idx_r;
    logic             we_r;
    logic [TW-1:0]    timer_r;
    logic [N-1:0]     match_s;
    logic             hit_s;
    logic [IW-1:0]    hit_idx_s;
    logic             capture_s;
    logic             resp_ack_s;
    logic             resp_err_s;
    logic             sel_ack_s;
    logic             sel_err_s;
    logic             timeout_s;
    logic [DW-1:0]    rdata_sel_s;

    logic [DW-1:0]    m_rdata_r;
    logic             m_ack_r;
    logic             m_err_r;
    logic [N-1:0]     s_cyc_r;
    logic [N-1:0]     s_stb_r;
    logic [N-1:0]     s_we_r;
    logic [N*AW-1:0]  s_addr_r;
    logic [N*DW-1:0]  s_wdata_r;
    logic [N*SW-1:0]  s_sel_r;

    assign m_rdata = m_rdata_r;
    assign m_ack   = m_ack_r;
    assign m_err   = m_err_r;
    assign s_cyc   = s_cyc_r;
    assign s_stb   = s_stb_r;
    assign s_we    = s_we_r;
    assign s_addr  = s_addr_r;
    assign s_wdata = s_wdata_r;
    assign s_sel   = s_sel_r;

    assign sel_ack_s = s_ack[idx_r];
    assign sel_err_s = s_err[idx_r];
    assign timeout_s = (TIMEOUT != 0) && (timer_r == TIMEOUT_LAST);

    // Address decode; scanning downwards lets the lowest matching slave win on overlap.
    always_comb begin
        hit_idx_s = '0;
        for (int i = 0; i < N; i++) begin
            match_s[i] = (m_addr >= ADDR_RANGES[(2*i+1)*AW +: AW]) &&
                         (m_addr <= ADDR_RANGES[2*i*AW +: AW]);
        end
        for (int i = N - 1; i >= 0; i--) begin
            hit_idx_s = match_s[i] ? IW'(i) : hit_idx_s;
        end
        hit_s = |match_s;
    end

    // Read-data mux for the currently selected slave.
    always_comb begin
        rdata_sel_s = '0;
        for (int i = 0; i < N; i++) begin
            rdata_sel_s = (idx_r == IW'(i)) ? s_rdata[i*DW +: DW] : rdata_sel_s;
        end
    end

    // Next-state logic; ACTIVE exits are prioritised abort > err > ack > timeout.
    always_comb begin
        next_state_s = state_r;
        capture_s    = 1'b0;
        resp_ack_s   = 1'b0;
        resp_err_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (m_cyc && m_stb) begin
                    if (hit_s) begin
                        next_state_s = ACTIVE;
                        capture_s    = 1'b1;
                    end else begin
                        next_state_s = RESP;
                        resp_err_s   = 1'b1;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            ACTIVE: begin
                if (!m_cyc) begin
                    next_state_s = IDLE;
                end else if (sel_err_s) begin
                    next_state_s = RESP;
                    resp_err_s   = 1'b1;
                end else if (sel_ack_s) begin
                    next_state_s = RESP;
                    resp_ack_s   = 1'b1;
                end else if (timeout_s) begin
                    next_state_s = RESP;
                    resp_err_s   = 1'b1;
                end else begin
                    next_state_s = ACTIVE;
                end
            end
            RESP:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Selected slave index, direction and watchdog timer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_r   <= '0;
            we_r    <= 1'b0;
            timer_r <= '0;
        end else if (capture_s) begin
            idx_r   <= hit_idx_s;
            we_r    <= m_we;
            timer_r <= '0;
        end else if (state_r == ACTIVE) begin
            timer_r <= timer_r + TW'(1);
        end
    end

    // Master response registers; read data only survives a read ack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ack_r   <= 1'b0;
            m_err_r   <= 1'b0;
            m_rdata_r <= '0;
        end else begin
            m_ack_r   <= resp_ack_s;
            m_err_r   <= resp_err_s;
            m_rdata_r <= (resp_ack_s && !we_r) ? rdata_sel_s : '0;
        end
    end

    // Slave-side request registers: loaded on accept, held while ACTIVE, cleared otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_cyc_r   <= '0;
            s_stb_r   <= '0;
            s_we_r    <= '0;
            s_addr_r  <= '0;
            s_wdata_r <= '0;
            s_sel_r   <= '0;
        end else if (capture_s) begin
            for (int i = 0; i < N; i++) begin
                s_cyc_r[i]              <= (hit_idx_s == IW'(i));
                s_stb_r[i]              <= (hit_idx_s == IW'(i));
                s_we_r[i]               <= (hit_idx_s == IW'(i)) && m_we;
                s_addr_r[i*AW +: AW]    <= (hit_idx_s == IW'(i)) ? m_addr : '0;
                s_wdata_r[i*DW +: DW]   <= (hit_idx_s == IW'(i)) ? m_wdata : '0;
                s_sel_r[i*SW +: SW]     <= (hit_idx_s == IW'(i)) ? m_sel : '0;
            end
        end else if (next_state_s != ACTIVE) begin
            s_cyc_r   <= '0;
            s_stb_r   <= '0;
            s_we_r    <= '0;
            s_addr_r  <= '0;
            s_wdata_r <= '0;
            s_sel_r   <= '0;
        end
    end

endmodule
